store_buffer: RTL and testbench

Posted-store buffer between the MEM-stage pipeline register and the data memory. It queues stores (word, halfword, byte) in FIFO order and drains one entry per cycle into the data memory whenever the memory port is idle. It raises `stall` when a new store finds the buffer full, or when a load touches a word that still has a pending store. Loads otherwise pass straight through to the memory address port.

---
 rtl/store_buffer_if.sv | 36 +++
 rtl/store_buffer.sv | 86 ++++++++
 tb/tb_store_buffer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// Bundle between MEM stage, store buffer and data memory.
// Pipeline/memory side is master; the buffer is slave.
interface store_buffer_if;
  logic        in_we;
  logic        in_memb;
  logic        in_memh;
  logic [31:0] in_addr;
  logic [31:0] in_wd;
  logic [31:0] in_pc;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic        stall;
  logic        dm_we;
  logic        dm_memb;
  logic        dm_memh;
  logic [31:0] dm_addr;
  logic [31:0] dm_wd;
  logic [31:0] dm_pc;
  logic        empty;

  modport master (
    output in_we, in_memb, in_memh,
    output in_addr, in_wd, in_pc,
    output ld_req, ld_addr,
    input  stall, dm_we, dm_memb, dm_memh,
    input  dm_addr, dm_wd, dm_pc, empty
  );

  modport slave (
    input  in_we, in_memb, in_memh,
    input  in_addr, in_wd, in_pc,
    input  ld_req, ld_addr,
    output stall, dm_we, dm_memb, dm_memh,
    output dm_addr, dm_wd, dm_pc, empty
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-store FIFO between MEM stage and data memory.
// Drains on idle cycles; stalls on full or same-word load.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           reset,
  store_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic        memb;
    logic        memh;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] pc;
  } ent_t;

  ent_t           mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [AW-1:0]  rd_q, rd_d;
  logic [AW-1:0]  wr_q, wr_d;
  logic [AW:0]    cnt_q, cnt_d;

  logic full, hit, drain, enq;
  ent_t head;

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] &&
          mem_q[i].addr[31:2] == bus.ld_addr[31:2])
        hit = 1'b1;
    end
    full  = (cnt_q == (AW+1)'(DEPTH));
    bus.stall = (bus.in_we & full) |
                (bus.ld_req & hit);
    drain = (cnt_q != '0) &
            (bus.stall | (~bus.ld_req & ~bus.in_we));
    enq   = bus.in_we & ~full;
    head  = mem_q[rd_q];

    bus.dm_we   = drain;
    bus.dm_memb = drain & head.memb;
    bus.dm_memh = drain & head.memh;
    bus.dm_wd   = drain ? head.wd : 32'h0;
    bus.dm_pc   = drain ? head.pc : 32'h0;
    bus.dm_addr = drain ? head.addr : bus.ld_addr;
    bus.empty   = (cnt_q == '0);

    // Index clash is impossible: enq+drain needs 0<count<DEPTH
    vld_d = vld_q;
    if (drain) vld_d[rd_q] = 1'b0;
    if (enq)   vld_d[wr_q] = 1'b1;
    rd_d  = rd_q + AW'(drain);
    wr_d  = wr_q + AW'(enq);
    cnt_d = cnt_q + (AW+1)'(enq) - (AW+1)'(drain);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && enq) begin
      mem_q[wr_q] <= '{
        memb: bus.in_memb,
        memh: bus.in_memh,
        addr: bus.in_addr,
        wd:   bus.in_wd,
        pc:   bus.in_pc
      };
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a write scoreboard.
// Stores are queued when presented; drains are popped and compared.
module tb_store_buffer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  store_buffer_if bus ();

  store_buffer #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        b;
    logic        h;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] p;
  } exp_t;

  exp_t sb[$];
  int nvec = 0;
  int nerr = 0;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.in_we  = 1'b0;
    bus.ld_req = 1'b0;
  endtask

  task automatic st(logic b, logic h, logic [31:0] a,
                    logic [31:0] d, logic [31:0] p);
    exp_t e;
    bus.in_we   = 1'b1;
    bus.in_memb = b;
    bus.in_memh = h;
    bus.in_addr = a;
    bus.in_wd   = d;
    bus.in_pc   = p;
    bus.ld_req  = 1'b0;
    e = '{b: b, h: h, a: a, d: d, p: p};
    sb.push_back(e);
  endtask

  task automatic ld(logic [31:0] a);
    bus.in_we   = 1'b0;
    bus.ld_req  = 1'b1;
    bus.ld_addr = a;
  endtask

  // Sample mid-cycle; check handshake and any drained write
  task automatic look(string tag, logic es, logic ewe);
    exp_t e;
    @(negedge clk);
    chk({tag, " stall"}, 32'(bus.stall), 32'(es));
    chk({tag, " dm_we"}, 32'(bus.dm_we), 32'(ewe));
    if (bus.dm_we) begin
      if (sb.size() == 0) begin
        chk({tag, " unexpected write"}, 32'(bus.dm_we), 32'h0);
      end else begin
        e = sb.pop_front();
        chk({tag, " addr"}, bus.dm_addr, e.a);
        chk({tag, " wd"}, bus.dm_wd, e.d);
        chk({tag, " pc"}, bus.dm_pc, e.p);
        chk({tag, " memb"}, 32'(bus.dm_memb), 32'(e.b));
        chk({tag, " memh"}, 32'(bus.dm_memh), 32'(e.h));
      end
    end else begin
      chk({tag, " wd idle"}, bus.dm_wd, 32'h0);
      chk({tag, " pc idle"}, bus.dm_pc, 32'h0);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic step(string tag, logic es, logic ewe);
    look(tag, es, ewe);
    nxt();
  endtask

  initial begin
    bus.in_we   = 1'b0;
    bus.in_memb = 1'b0;
    bus.in_memh = 1'b0;
    bus.in_addr = '0;
    bus.in_wd   = '0;
    bus.in_pc   = '0;
    bus.ld_req  = 1'b0;
    bus.ld_addr = 32'h0000_0abc;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset state over idle cycles
    for (int i = 0; i < 3; i++) begin
      look("rst", 1'b0, 1'b0);
      chk("rst empty", 32'(bus.empty), 32'h1);
      chk("rst dm_addr", bus.dm_addr, 32'h0000_0abc);
      nxt();
    end

    // single word store then drain
    st(1'b0, 1'b0, 32'h10, 32'h1234_5678, 32'h100);
    step("sw", 1'b0, 1'b0);
    idle();
    look("sw drain", 1'b0, 1'b1);
    chk("sw empty0", 32'(bus.empty), 32'h0);
    nxt();
    look("sw after", 1'b0, 1'b0);
    chk("sw empty1", 32'(bus.empty), 32'h1);
    nxt();

    // fill past capacity
    for (int i = 0; i < 4; i++) begin
      st(1'b0, 1'b0, 32'h100 + 32'(4*i),
         32'ha0 + 32'(i), 32'h1000 + 32'(4*i));
      step("fill", 1'b0, 1'b0);
    end
    st(1'b0, 1'b0, 32'h110, 32'ha4, 32'h1010);
    step("full", 1'b1, 1'b1);
    step("full held", 1'b0, 1'b0);
    idle();
    for (int i = 0; i < 4; i++) step("fdrain", 1'b0, 1'b1);
    look("fdone", 1'b0, 1'b0);
    chk("fdone empty", 32'(bus.empty), 32'h1);
    nxt();

    // load hit on byte store at head
    st(1'b1, 1'b0, 32'h20, 32'hab, 32'h2000);
    step("hb0", 1'b0, 1'b0);
    st(1'b0, 1'b0, 32'h40, 32'h4040_4040, 32'h2004);
    step("hb1", 1'b0, 1'b0);
    st(1'b0, 1'b0, 32'h24, 32'h2424_2424, 32'h2008);
    step("hb2", 1'b0, 1'b0);
    ld(32'h22);
    look("hit", 1'b1, 1'b1);
    chk("hit dm_addr", bus.dm_addr, 32'h20);
    chk("hit memb", 32'(bus.dm_memb), 32'h1);
    nxt();
    look("hit go", 1'b0, 1'b0);
    chk("hit go addr", bus.dm_addr, 32'h22);
    chk("hit go memb", 32'(bus.dm_memb), 32'h0);
    nxt();
    idle();
    step("hdrain", 1'b0, 1'b1);
    step("hdrain", 1'b0, 1'b1);
    look("hdone", 1'b0, 1'b0);
    chk("hdone empty", 32'(bus.empty), 32'h1);
    nxt();

    // load hit on youngest entry: stall three cycles
    st(1'b0, 1'b0, 32'h40, 32'h1111_1111, 32'h3000);
    step("y0", 1'b0, 1'b0);
    st(1'b0, 1'b1, 32'h44, 32'h2222, 32'h3004);
    step("y1", 1'b0, 1'b0);
    st(1'b0, 1'b0, 32'h48, 32'h3333_3333, 32'h3008);
    step("y2", 1'b0, 1'b0);
    ld(32'h48);
    for (int i = 0; i < 3; i++) step("ystall", 1'b1, 1'b1);
    look("ygo", 1'b0, 1'b0);
    chk("ygo empty", 32'(bus.empty), 32'h1);
    chk("ygo addr", bus.dm_addr, 32'h48);
    nxt();

    // reset discards pending stores
    st(1'b0, 1'b0, 32'h200, 32'h5555_5555, 32'h4000);
    step("r0", 1'b0, 1'b0);
    st(1'b0, 1'b0, 32'h204, 32'h6666_6666, 32'h4004);
    step("r1", 1'b0, 1'b0);
    idle();
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    sb.delete();
    for (int i = 0; i < 2; i++) begin
      look("post rst", 1'b0, 1'b0);
      chk("post rst empty", 32'(bus.empty), 32'h1);
      nxt();
    end

    chk("scoreboard drained", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end
endmodule
